calc_entry_ctrl: RTL

CALC_ENTRY_CTRL -- requirements
Module: calc_entry_ctrl

---
 rtl/calc_entry_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_entry_ctrl.sv
// Keypad entry controller for a two-operand BCD calculator: collects digits and
// operators, hands operand pairs to an external ALU and drives the display.
module calc_entry_ctrl #(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_press,
    input  logic              is_num,
    input  logic              is_op,
    input  logic              is_eq,
    input  logic [3:0]        num_val,
    input  logic [1:0]        op_val,
    output logic              alu_req,
    output logic [4*NDIG-1:0] alu_a,
    output logic [4*NDIG-1:0] alu_b,
    output logic              alu_a_neg,
    output logic [1:0]        alu_op,
    input  logic              alu_ack,
    input  logic [4*NDIG-1:0] alu_result,
    input  logic              alu_neg,
    input  logic              alu_ovf,
    output logic [4*NDIG-1:0] disp_val,
    output logic              disp_neg,
    output logic              disp_err,
    output logic              busy
);

    // state   | meaning
    // ENTER_A | collecting digits of operand A
    // OP_WAIT | operator latched, waiting for first digit of B
    // ENTER_B | collecting digits of operand B
    // EXEC    | ALU request outstanding, keys discarded
    // SHOW    | result displayed as A
    // ERR     | overflow reported, next key clears everything
    typedef enum logic [2:0] {ENTER_A, OP_WAIT, ENTER_B, EXEC, SHOW, ERR} state_t;

    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(NDIG + 1);

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [1:0]      op_q, op_d, pend_q, pend_d;
    logic            chain_q, chain_d;
    logic            a_neg_q, a_neg_d;
    logic            btn_q;

    logic            alu_req_q, alu_req_d;
    logic [W-1:0]    alu_a_q, alu_b_q, disp_val_q, disp_val_d;
    logic            alu_a_neg_q, disp_neg_q, disp_neg_d, disp_err_q, busy_q;
    logic [1:0]      alu_op_q;

    logic            ev, key_num, key_op, key_eq, num_zero;

    assign ev       = btn_press & ~btn_q;
    assign key_num  = ev & is_num;
    assign key_op   = ev & ~is_num & is_op & ((op_val == 2'd1) || (op_val == 2'd2));
    assign key_eq   = ev & ~is_num & ~is_op & is_eq;
    assign num_zero = (num_val == 4'd0);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        op_d    = op_q;
        pend_d  = pend_q;
        chain_d = chain_q;
        a_neg_d = a_neg_q;
        case (state_q)
            ENTER_A: begin
                if (key_num) begin
                    // leading zeros leave both operand and count untouched
                    if (!(num_zero && a_q == '0) && cnt_a_q < CW'(NDIG)) begin
                        a_d     = {a_q[W-5:0], num_val};
                        cnt_a_d = cnt_a_q + CW'(1);
                    end
                end else if (key_op) begin
                    op_d    = op_val;
                    state_d = OP_WAIT;
                end
            end
            OP_WAIT: begin
                if (key_num) begin
                    b_d     = W'(num_val);
                    cnt_b_d = num_zero ? CW'(0) : CW'(1);
                    state_d = ENTER_B;
                end else if (key_op) begin
                    op_d = op_val;
                end
            end
            ENTER_B: begin
                if (key_num) begin
                    if (!(num_zero && b_q == '0) && cnt_b_q < CW'(NDIG)) begin
                        b_d     = {b_q[W-5:0], num_val};
                        cnt_b_d = cnt_b_q + CW'(1);
                    end
                end else if (key_op) begin
                    pend_d  = op_val;
                    chain_d = 1'b1;
                    state_d = EXEC;
                end else if (key_eq) begin
                    chain_d = 1'b0;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (alu_ack) begin
                    chain_d = 1'b0;
                    if (alu_ovf) begin
                        state_d = ERR;
                    end else begin
                        a_d     = alu_result;
                        a_neg_d = alu_neg;
                        cnt_a_d = CW'(NDIG);
                        if (chain_q) begin
                            op_d    = pend_q;
                            state_d = OP_WAIT;
                        end else begin
                            state_d = SHOW;
                        end
                    end
                end
            end
            SHOW: begin
                if (key_num) begin
                    a_d     = W'(num_val);
                    a_neg_d = 1'b0;
                    cnt_a_d = num_zero ? CW'(0) : CW'(1);
                    state_d = ENTER_A;
                end else if (key_op) begin
                    op_d    = op_val;
                    state_d = OP_WAIT;
                end
            end
            ERR: begin
                if (ev) begin
                    a_d     = '0;
                    b_d     = '0;
                    a_neg_d = 1'b0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    state_d = ENTER_A;
                end
            end
            default: state_d = ENTER_A;
        endcase

        alu_req_d  = (state_d == EXEC);
        disp_val_d = (state_d == ENTER_B) ? b_d : a_d;
        disp_neg_d = (state_d == ENTER_B) ? 1'b0 : a_neg_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ENTER_A;
            a_q         <= '0;
            b_q         <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            op_q        <= '0;
            pend_q      <= '0;
            chain_q     <= 1'b0;
            a_neg_q     <= 1'b0;
            btn_q       <= 1'b1;
            alu_req_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_a_neg_q <= 1'b0;
            alu_op_q    <= '0;
            disp_val_q  <= '0;
            disp_neg_q  <= 1'b0;
            disp_err_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            op_q        <= op_d;
            pend_q      <= pend_d;
            chain_q     <= chain_d;
            a_neg_q     <= a_neg_d;
            btn_q       <= btn_press;
            alu_req_q   <= alu_req_d;
            alu_a_q     <= a_d;
            alu_b_q     <= b_d;
            alu_a_neg_q <= a_neg_d;
            alu_op_q    <= op_d;
            disp_val_q  <= disp_val_d;
            disp_neg_q  <= disp_neg_d;
            disp_err_q  <= (state_d == ERR);
            busy_q      <= (state_d == EXEC);
        end
    end

    assign alu_req   = alu_req_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_a_neg = alu_a_neg_q;
    assign alu_op    = alu_op_q;
    assign disp_val  = disp_val_q;
    assign disp_neg  = disp_neg_q;
    assign disp_err  = disp_err_q;
    assign busy      = busy_q;

endmodule
